// File: rtl/sram_march_bist_ctrl.sv
// March C- self-test controller for one single-port SRAM.
// Drives the BIST port group and scores every read one cycle later.
module sram_march_bist_ctrl #(
  parameter int P_DATA_WIDTH = 24,
  parameter int P_ADDR_WIDTH = 14,
  parameter int DEPTH        = 256,
  parameter int P_CNT_WIDTH  = 16
) (
  input  logic                    A_CLK,
  input  logic                    A_RST,
  input  logic                    START,
  output logic                    BUSY,
  output logic                    DONE,
  output logic                    FAIL,
  output logic [P_ADDR_WIDTH-1:0] FAIL_ADDR,
  output logic [2:0]              FAIL_ELEM,
  output logic [P_CNT_WIDTH-1:0]  FAIL_CNT,
  output logic                    BIST_EN,
  output logic [P_ADDR_WIDTH-1:0] BIST_ADDR,
  output logic [P_DATA_WIDTH-1:0] BIST_DIN,
  output logic [P_DATA_WIDTH-1:0] BIST_BM,
  output logic                    BIST_MEN,
  output logic                    BIST_WEN,
  output logic                    BIST_REN,
  input  logic [P_DATA_WIDTH-1:0] BIST_DOUT
);

  typedef enum logic [3:0] {
    S_IDLE, S_M0, S_M1, S_M2, S_M3,
    S_M4, S_M5, S_DRAIN, S_DONE
  } state_t;

  localparam logic [P_ADDR_WIDTH-1:0] LAST =
    P_ADDR_WIDTH'(DEPTH - 1);

  state_t                  state_q, state_d;
  logic [P_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                    wr_q, wr_d;
  logic                    rd_vld_q, rd_vld_d;
  logic                    rd_one_q, rd_one_d;
  logic [P_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [2:0]              rd_elem_q, rd_elem_d;
  logic                    fail_q, fail_d;
  logic [P_ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
  logic [2:0]              fail_elem_q, fail_elem_d;
  logic [P_CNT_WIDTH-1:0]  fail_cnt_q, fail_cnt_d;

  logic       busy;
  logic       ren;
  logic       wen;
  logic       wr_one;
  logic       rd_one;
  logic [2:0] elem;
  logic       miss;

  always_comb begin
    busy   = 1'b1;
    ren    = 1'b0;
    wen    = 1'b0;
    wr_one = 1'b0;
    rd_one = 1'b0;
    elem   = 3'd0;
    unique case (state_q)
      S_M0: wen = 1'b1;
      S_M1: begin
        elem = 3'd1; ren = !wr_q;
        wen = wr_q; wr_one = 1'b1;
      end
      S_M2: begin
        elem = 3'd2; ren = !wr_q;
        wen = wr_q; rd_one = 1'b1;
      end
      S_M3: begin
        elem = 3'd3; ren = !wr_q;
        wen = wr_q; wr_one = 1'b1;
      end
      S_M4: begin
        elem = 3'd4; ren = !wr_q;
        wen = wr_q; rd_one = 1'b1;
      end
      S_M5: begin
        elem = 3'd5; ren = 1'b1;
      end
      S_DRAIN: ;
      default: busy = 1'b0;
    endcase
  end

  assign miss = rd_vld_q &&
    (BIST_DOUT != {P_DATA_WIDTH{rd_one_q}});

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wr_d        = wr_q;
    rd_vld_d    = ren;
    rd_one_d    = rd_one;
    rd_addr_d   = addr_q;
    rd_elem_d   = elem;
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    fail_elem_d = fail_elem_q;
    fail_cnt_d  = fail_cnt_q;

    if (miss) begin
      fail_d = 1'b1;
      if (!fail_q) begin
        fail_addr_d = rd_addr_q;
        fail_elem_d = rd_elem_q;
      end
      if (fail_cnt_q != {P_CNT_WIDTH{1'b1}})
        fail_cnt_d = fail_cnt_q + P_CNT_WIDTH'(1);
    end

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (START) begin
          state_d     = S_M0;
          addr_d      = '0;
          wr_d        = 1'b0;
          fail_d      = 1'b0;
          fail_addr_d = '0;
          fail_elem_d = '0;
          fail_cnt_d  = '0;
        end
      end
      S_M0: begin
        if (addr_q == LAST) begin
          state_d = S_M1;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      S_M1, S_M2: begin
        wr_d = !wr_q;
        if (wr_q) begin
          if (addr_q == LAST) begin
            state_d = (state_q == S_M1) ? S_M2 : S_M3;
            addr_d  = (state_q == S_M1) ? '0 : LAST;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      S_M3, S_M4: begin
        wr_d = !wr_q;
        if (wr_q) begin
          if (addr_q == '0) begin
            state_d = (state_q == S_M3) ? S_M4 : S_M5;
            addr_d  = (state_q == S_M3) ? LAST : '0;
          end else begin
            addr_d = addr_q - 1'b1;
          end
        end
      end
      S_M5: begin
        if (addr_q == LAST) begin
          state_d = S_DRAIN;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      S_DRAIN: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge A_CLK) begin
    if (A_RST) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wr_q        <= 1'b0;
      rd_vld_q    <= 1'b0;
      rd_one_q    <= 1'b0;
      rd_addr_q   <= '0;
      rd_elem_q   <= '0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= '0;
      fail_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wr_q        <= wr_d;
      rd_vld_q    <= rd_vld_d;
      rd_one_q    <= rd_one_d;
      rd_addr_q   <= rd_addr_d;
      rd_elem_q   <= rd_elem_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
      fail_cnt_q  <= fail_cnt_d;
    end
  end

  assign BUSY      = busy;
  assign DONE      = (state_q == S_DONE);
  assign FAIL      = fail_q;
  assign FAIL_ADDR = fail_addr_q;
  assign FAIL_ELEM = fail_elem_q;
  assign FAIL_CNT  = fail_cnt_q;
  assign BIST_EN   = busy;
  assign BIST_MEN  = busy;
  assign BIST_BM   = {P_DATA_WIDTH{busy}};
  assign BIST_ADDR = busy ? addr_q : '0;
  assign BIST_WEN  = wen;
  assign BIST_REN  = ren;
  assign BIST_DIN  = {P_DATA_WIDTH{wen & wr_one}};

endmodule

// File: tb/tb_sram_march_bist_ctrl.sv
// Directed bench for sram_march_bist_ctrl with a 16-word SRAM model.
// A second instance sees a constant read bus to exercise saturation.
module tb_sram_march_bist_ctrl;

  localparam int DW = 24;
  localparam int AW = 14;
  localparam int D  = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          fault;
  logic          busy, done, fail;
  logic [AW-1:0] fail_addr;
  logic [2:0]    fail_elem;
  logic [15:0]   fail_cnt;
  logic          en, men, wen, ren;
  logic [AW-1:0] addr;
  logic [DW-1:0] din, bm, dout;

  logic          b_busy, b_done, b_fail;
  logic [AW-1:0] b_fail_addr;
  logic [2:0]    b_fail_elem;
  logic [1:0]    b_fail_cnt;
  logic          b_en, b_men, b_wen, b_ren;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_din, b_bm;
  logic [DW-1:0] b_dout = 24'h000001;

  logic [DW-1:0] mem [D];

  int n_chk = 0;
  int n_fail = 0;
  logic mon_clr;
  int nw, nr, merr;

  always #5 clk = ~clk;

  sram_march_bist_ctrl #(
    .P_DATA_WIDTH(DW), .P_ADDR_WIDTH(AW),
    .DEPTH(D), .P_CNT_WIDTH(16)
  ) u_dut (
    .A_CLK(clk), .A_RST(rst), .START(start),
    .BUSY(busy), .DONE(done), .FAIL(fail),
    .FAIL_ADDR(fail_addr), .FAIL_ELEM(fail_elem),
    .FAIL_CNT(fail_cnt), .BIST_EN(en),
    .BIST_ADDR(addr), .BIST_DIN(din),
    .BIST_BM(bm), .BIST_MEN(men),
    .BIST_WEN(wen), .BIST_REN(ren),
    .BIST_DOUT(dout)
  );

  sram_march_bist_ctrl #(
    .P_DATA_WIDTH(DW), .P_ADDR_WIDTH(AW),
    .DEPTH(D), .P_CNT_WIDTH(2)
  ) u_dut_b (
    .A_CLK(clk), .A_RST(rst), .START(start),
    .BUSY(b_busy), .DONE(b_done), .FAIL(b_fail),
    .FAIL_ADDR(b_fail_addr), .FAIL_ELEM(b_fail_elem),
    .FAIL_CNT(b_fail_cnt), .BIST_EN(b_en),
    .BIST_ADDR(b_addr), .BIST_DIN(b_din),
    .BIST_BM(b_bm), .BIST_MEN(b_men),
    .BIST_WEN(b_wen), .BIST_REN(b_ren),
    .BIST_DOUT(b_dout)
  );

  // Behavioural SRAM; bit 0 of word 5 reads back as 1 when fault is set.
  always @(posedge clk) begin
    if (men && wen)
      mem[addr[3:0]] <= (mem[addr[3:0]] & ~bm) | (din & bm);
    if (men && ren)
      dout <= mem[addr[3:0]] |
        ((fault && addr == 14'd5) ? 24'h1 : 24'h0);
  end

  function automatic int exp_rd_addr(input int i);
    int e = i / D;
    int j = i % D;
    return (e == 2 || e == 3) ? (D - 1 - j) : j;
  endfunction

  always @(negedge clk) begin
    if (mon_clr) begin
      nw <= 0; nr <= 0; merr <= 0;
    end else begin
      if (wen && ren) merr <= merr + 1;
      if (busy && (bm != '1 || !men || !en))
        merr <= merr + 1;
      if (wen) nw <= nw + 1;
      if (ren) begin
        nr <= nr + 1;
        if (int'(addr) != exp_rd_addr(nr))
          merr <= merr + 1;
      end
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_run(input int hold, output int len);
    len = 0;
    start = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (busy) len++;
    end
    start = 1'b0;
    while (busy && len < 400) begin
      @(posedge clk); #1;
      if (busy) len++;
    end
  endtask

  int len;
  int nz;

  initial begin
    rst = 1'b1; start = 1'b0;
    fault = 1'b1; mon_clr = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_fail", fail, 0);
    check("rst_cnt", fail_cnt, 0);
    check("rst_en", en, 0);
    check("rst_wr_rd", {wen, ren, men}, 0);
    check("rst_bm", bm, 0);
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    // stuck-at fault run, start sampled at edge 10
    do_run(1, len);
    check("flt_len", len, 161);
    check("flt_done", done, 1);
    check("flt_fail", fail, 1);
    check("flt_addr", fail_addr, 5);
    check("flt_elem", fail_elem, 1);
    check("flt_cnt", fail_cnt, 3);
    check("sat_fail", b_fail, 1);
    check("sat_cnt", b_fail_cnt, 3);
    check("sat_addr", b_fail_addr, 0);
    check("sat_elem", b_fail_elem, 1);
    check("sat_done", b_done, 1);
    check("idle_en", {en, wen, ren, men}, 0);

    // restart from DONE, fault-free, with protocol monitor
    fault = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("done_hold", done, 1);
    mon_clr = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("rs_busy", busy, 1);
    check("rs_done", done, 0);
    check("rs_fail", fail, 0);
    check("rs_cnt", fail_cnt, 0);
    check("rs_faddr", fail_addr, 0);
    len = 1;
    while (busy && len < 400) begin
      @(posedge clk); #1;
      if (busy) len++;
    end
    check("ok_len", len, 161);
    check("ok_done", done, 1);
    check("ok_fail", fail, 0);
    check("ok_cnt", fail_cnt, 0);
    check("mon_wr", nw, 5 * D);
    check("mon_rd", nr, 5 * D);
    check("mon_err", merr, 0);
    nz = 0;
    for (int i = 0; i < D; i++)
      if (mem[i] != 24'h0) nz++;
    check("mem_zero", nz, 0);
    mon_clr = 1'b1;

    // reset 40 cycles into a run, then rerun cleanly
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (39) @(posedge clk);
    #1;
    check("mid_busy", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("ab_busy", busy, 0);
    check("ab_en", en, 0);
    check("ab_done", done, 0);
    do_run(1, len);
    check("ar_len", len, 161);
    check("ar_done", done, 1);
    check("ar_fail", fail, 0);

    // START held for 20 cycles must not restart
    @(posedge clk); #1;
    do_run(20, len);
    check("hold_len", len, 161);
    check("hold_done", done, 1);
    check("hold_fail", fail, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
